// File: rtl/reg_pkg.sv
// reg_pkg: shared widths, FSM state encoding, response payload and helpers
// for the register-bank read port.
//   REG_W   - register data width
//   NREGS   - number of registers in the bank
//   IDX_W   - register index width
//   CNT_W   - accepted-request counter width
package reg_pkg;

  localparam int unsigned REG_W = 16;
  localparam int unsigned NREGS = 16;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned CNT_W = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Payload held by the single-entry response buffer.
  typedef struct packed {
    logic [REG_W-1:0] src;
    logic [REG_W-1:0] dst;
    logic [IDX_W-1:0] src_idx;
    logic [IDX_W-1:0] dst_idx;
  } rsp_t;

  // True when two or more bits of v are set (clearing the lowest set bit
  // leaves something behind).
  function automatic logic multi_hot(input logic [NREGS-1:0] v);
    return (v & (v - NREGS'(1))) != '0;
  endfunction

endpackage

// File: rtl/reg_mux16.sv
// reg_mux16: 16:1 combinational selector over the flattened register bank.
// Ports:
//   sel     in   IDX_W        register index
//   data    in   NREGS*REG_W  bank contents, register i at [i*REG_W +: REG_W]
//   data_c  out  REG_W        selected register (combinational)
module reg_mux16
  import reg_pkg::*;
(
  input  logic [IDX_W-1:0]       sel,
  input  logic [NREGS*REG_W-1:0] data,
  output logic [REG_W-1:0]       data_c
);

  // Compare-and-select over every slot; synthesises to a plain mux tree.
  always_comb begin
    data_c = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (sel == IDX_W'(i)) begin
        data_c = data[i*REG_W +: REG_W];
      end
    end
  end

endmodule

// File: rtl/reg_read_port.sv
// reg_read_port: single-entry response buffer that reads two operands
// (source and destination) from a 16-entry register bank per request.
// Optional feature: define REG_BYPASS_EN to forward same-cycle bank writes
// into the captured operands and into a stalled, held response.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   r0..r15      in   16       register bank contents
//   wr_data      in   16       data written to the bank this cycle
//   wr_en        in   16       one-hot bank write enable
//   req_valid    in   1        read request present
//   req_ready    out  1        request can be accepted (combinational)
//   rsrc, rdst   in   4        source / destination indices
//   rsp_valid    out  1        response held
//   rsp_ready    in   1        consumer takes the response
//   src_data, dst_data  out 16 held operand values
//   rsp_src_idx, rsp_dst_idx out 4  indices of the held response
//   rd_count     out  16       accepted requests, wraps
//   onehot_err   out  1        sticky: wr_en ever had >= 2 bits set
module reg_read_port
  import reg_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] r0,
  input  logic [REG_W-1:0] r1,
  input  logic [REG_W-1:0] r2,
  input  logic [REG_W-1:0] r3,
  input  logic [REG_W-1:0] r4,
  input  logic [REG_W-1:0] r5,
  input  logic [REG_W-1:0] r6,
  input  logic [REG_W-1:0] r7,
  input  logic [REG_W-1:0] r8,
  input  logic [REG_W-1:0] r9,
  input  logic [REG_W-1:0] r10,
  input  logic [REG_W-1:0] r11,
  input  logic [REG_W-1:0] r12,
  input  logic [REG_W-1:0] r13,
  input  logic [REG_W-1:0] r14,
  input  logic [REG_W-1:0] r15,
  input  logic [REG_W-1:0] wr_data,
  input  logic [NREGS-1:0] wr_en,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [IDX_W-1:0] rsrc,
  input  logic [IDX_W-1:0] rdst,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [REG_W-1:0] src_data,
  output logic [REG_W-1:0] dst_data,
  output logic [IDX_W-1:0] rsp_src_idx,
  output logic [IDX_W-1:0] rsp_dst_idx,
  output logic [CNT_W-1:0] rd_count,
  output logic             onehot_err
);

  state_t                 state;
  rsp_t                   rsp;
  logic                   accept_c;
  logic [NREGS*REG_W-1:0] bank_c;
  logic [REG_W-1:0]       src_mux_c;
  logic [REG_W-1:0]       dst_mux_c;
  logic [REG_W-1:0]       src_cap_c;
  logic [REG_W-1:0]       dst_cap_c;

  // Flatten the bank, r0 in the low slot.
  assign bank_c = {r15, r14, r13, r12, r11, r10, r9, r8,
                   r7,  r6,  r5,  r4,  r3,  r2,  r1, r0};

  reg_mux16 u_src_mux (
    .sel    (rsrc),
    .data   (bank_c),
    .data_c (src_mux_c)
  );

  reg_mux16 u_dst_mux (
    .sel    (rdst),
    .data   (bank_c),
    .data_c (dst_mux_c)
  );

  // Operand values captured on accept; with bypass, a write landing this
  // cycle on the selected register wins over the stale bank value.
`ifdef REG_BYPASS_EN
  assign src_cap_c = wr_en[rsrc] ? wr_data : src_mux_c;
  assign dst_cap_c = wr_en[rdst] ? wr_data : dst_mux_c;
`else
  assign src_cap_c = src_mux_c;
  assign dst_cap_c = dst_mux_c;
`endif

  // Ready while empty, or while full and the held response leaves this edge.
  assign req_ready = (state == EMPTY) || rsp_ready;
  assign accept_c  = req_valid && req_ready;

  // Buffer state, payload, counter and error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= EMPTY;
      rsp        <= '0;
      rd_count   <= '0;
      onehot_err <= 1'b0;
    end else begin
      if (multi_hot(wr_en)) begin
        onehot_err <= 1'b1;
      end

      if (accept_c) begin
        // Covers both EMPTY->FULL and a bubble-free FULL->FULL refill.
        state       <= FULL;
        rsp.src     <= src_cap_c;
        rsp.dst     <= dst_cap_c;
        rsp.src_idx <= rsrc;
        rsp.dst_idx <= rdst;
        rd_count    <= rd_count + CNT_W'(1);
      end else if (state == FULL) begin
        if (rsp_ready) begin
          state <= EMPTY;
        end else begin
`ifdef REG_BYPASS_EN
          // Stalled: keep the held operands coherent with bank writes.
          if (wr_en[rsp.src_idx]) begin
            rsp.src <= wr_data;
          end
          if (wr_en[rsp.dst_idx]) begin
            rsp.dst <= wr_data;
          end
`endif
        end
      end
    end
  end

  assign rsp_valid   = (state == FULL);
  assign src_data    = rsp.src;
  assign dst_data    = rsp.dst;
  assign rsp_src_idx = rsp.src_idx;
  assign rsp_dst_idx = rsp.dst_idx;

endmodule
